// File: rtl/clk_ratio_meter.sv
// Measures a divided clock, sampled as data in the reference domain, and reports
// reference cycles per divided-clock period with lock and overflow indication.
module clk_ratio_meter #(
  parameter int DIV_RATIO_WIDTH = 8,
  parameter int LOCK_COUNT      = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                       i_ref_clk,
  input  logic                       i_rst_n,
  input  logic                       i_en,
  input  logic                       i_div_clk,
  output logic [DIV_RATIO_WIDTH-1:0] o_ratio,
  output logic                       o_valid,
  output logic                       o_locked,
  output logic                       o_overflow,
  output logic [1:0]                 dbg_state
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [DIV_RATIO_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [MW-1:0]              LOCK_N  = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEEK    = 2'd1,
    MEASURE = 2'd2
  } state_t;

  // Output handshake: o_valid is a single-cycle strobe with no backpressure;
  // o_ratio is stable from that cycle until the next strobe.

  logic [SYNC_STAGES-1:0]     sync_q;
  logic                       sync_prev;
  logic                       rise;
  state_t                     state_q, state_d;
  logic [DIV_RATIO_WIDTH-1:0] cnt_q, cnt_d;
  logic [MW-1:0]              match_q, match_d, match_inc;
  logic [DIV_RATIO_WIDTH-1:0] ratio_d;
  logic                       valid_d, locked_d, ovf_d;

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], i_div_clk};
      sync_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise      = sync_q[SYNC_STAGES-1] & ~sync_prev;
  assign match_inc = (match_q >= LOCK_N) ? LOCK_N : match_q + MW'(1);

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      match_q    <= '0;
      o_ratio    <= '0;
      o_valid    <= 1'b0;
      o_locked   <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      match_q    <= match_d;
      o_ratio    <= ratio_d;
      o_valid    <= valid_d;
      o_locked   <= locked_d;
      o_overflow <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    match_d  = match_q;
    ratio_d  = o_ratio;
    valid_d  = 1'b0;
    locked_d = o_locked;
    ovf_d    = o_overflow;
    if (!i_en) begin
      state_d  = IDLE;
      cnt_d    = '0;
      match_d  = '0;
      locked_d = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = SEEK;
        SEEK: begin
          if (rise) begin
            cnt_d   = DIV_RATIO_WIDTH'(1);
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          // An edge on the saturation cycle is a valid measurement of CNT_MAX.
          if (rise) begin
            ratio_d  = cnt_q;
            valid_d  = 1'b1;
            cnt_d    = DIV_RATIO_WIDTH'(1);
            ovf_d    = 1'b0;
            // match_q is nonzero only when a prior measurement exists.
            match_d  = (match_q != '0 && cnt_q == o_ratio) ? match_inc : MW'(1);
            locked_d = (match_d >= LOCK_N);
          end else if (cnt_q == CNT_MAX) begin
            ovf_d    = 1'b1;
            locked_d = 1'b0;
            match_d  = '0;
            cnt_d    = '0;
            state_d  = SEEK;
          end else begin
            cnt_d = cnt_q + DIV_RATIO_WIDTH'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed bench for clk_ratio_meter: ratio measurement, lock, timeout,
// enable gating and asynchronous reset.
module tb_clk_ratio_meter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         div_clk = 1'b0;
  logic [W-1:0] o_ratio;
  logic         o_valid;
  logic         o_locked;
  logic         o_overflow;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  clk_ratio_meter #(
    .DIV_RATIO_WIDTH(W),
    .LOCK_COUNT(4),
    .SYNC_STAGES(2)
  ) dut (
    .i_ref_clk (clk),
    .i_rst_n   (rst_n),
    .i_en      (en),
    .i_div_clk (div_clk),
    .o_ratio   (o_ratio),
    .o_valid   (o_valid),
    .o_locked  (o_locked),
    .o_overflow(o_overflow),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One divided-clock period starting with a rising edge; the result of that
  // edge is expected three negedges after it is driven.
  task automatic period(input string tag, input int hi, input int lo, input bit exp_v,
                        input int exp_r, input bit exp_l, input bit exp_ovf);
    for (int i = 0; i < hi + lo; i++) begin
      @(negedge clk);
      if (i == 3) begin
        check({tag, ".valid"}, 32'(o_valid), 32'(exp_v));
        if (exp_v) check({tag, ".ratio"}, 32'(o_ratio), 32'(exp_r));
        check({tag, ".locked"}, 32'(o_locked), 32'(exp_l));
        check({tag, ".overflow"}, 32'(o_overflow), 32'(exp_ovf));
      end else begin
        check({tag, ".novalid"}, 32'(o_valid), 32'd0);
      end
      div_clk = (i < hi);
    end
  endtask

  task automatic quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, 32'(o_valid), 32'd0);
    end
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst.ratio", 32'(o_ratio), 32'd0);
    check("rst.valid", 32'(o_valid), 32'd0);
    check("rst.locked", 32'(o_locked), 32'd0);
    check("rst.overflow", 32'(o_overflow), 32'd0);
    check("rst.state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
    check("en.state_seek", 32'(dbg_state), 32'd1);

    // ratio 4, 50% duty: lock on the 5th edge
    period("r4_1", 2, 2, 1'b0, 0, 1'b0, 1'b0);
    period("r4_2", 2, 2, 1'b1, 4, 1'b0, 1'b0);
    period("r4_3", 2, 2, 1'b1, 4, 1'b0, 1'b0);
    period("r4_4", 2, 2, 1'b1, 4, 1'b0, 1'b0);
    period("r4_5", 2, 2, 1'b1, 4, 1'b1, 1'b0);
    period("r4_6", 2, 2, 1'b1, 4, 1'b1, 1'b0);

    // ratio 5, high 2 / low 3
    period("r5_1", 2, 3, 1'b1, 4, 1'b1, 1'b0);
    period("r5_2", 2, 3, 1'b1, 5, 1'b0, 1'b0);
    period("r5_3", 2, 3, 1'b1, 5, 1'b0, 1'b0);
    period("r5_4", 2, 3, 1'b1, 5, 1'b0, 1'b0);
    period("r5_5", 2, 3, 1'b1, 5, 1'b1, 1'b0);

    // ratio 6 lock, then switch to ratio 8
    period("r6_1", 3, 3, 1'b1, 5, 1'b1, 1'b0);
    period("r6_2", 3, 3, 1'b1, 6, 1'b0, 1'b0);
    period("r6_3", 3, 3, 1'b1, 6, 1'b0, 1'b0);
    period("r6_4", 3, 3, 1'b1, 6, 1'b0, 1'b0);
    period("r6_5", 3, 3, 1'b1, 6, 1'b1, 1'b0);
    period("r8_0", 4, 4, 1'b1, 6, 1'b1, 1'b0);
    period("r8_1", 4, 4, 1'b1, 8, 1'b0, 1'b0);
    period("r8_2", 4, 4, 1'b1, 8, 1'b0, 1'b0);
    period("r8_3", 4, 4, 1'b1, 8, 1'b0, 1'b0);
    period("r8_4", 4, 4, 1'b1, 8, 1'b1, 1'b0);

    // input stuck low: timeout when the count reaches 255 with no edge
    quiet("stuck.novalid", 250);
    check("stuck.ovf_before", 32'(o_overflow), 32'd0);
    check("stuck.locked_before", 32'(o_locked), 32'd1);
    quiet("stuck.novalid", 1);
    check("stuck.overflow", 32'(o_overflow), 32'd1);
    check("stuck.locked", 32'(o_locked), 32'd0);
    check("stuck.ratio_held", 32'(o_ratio), 32'd8);
    check("stuck.state_seek", 32'(dbg_state), 32'd1);

    // exact ratio 255: edge on the saturation cycle wins over the timeout
    period("r255_1", 100, 155, 1'b0, 0, 1'b0, 1'b1);
    period("r255_2", 2, 2, 1'b1, 255, 1'b0, 1'b0);

    // relock at ratio 4, then drop enable mid-period
    period("re4_1", 2, 2, 1'b1, 4, 1'b0, 1'b0);
    period("re4_2", 2, 2, 1'b1, 4, 1'b0, 1'b0);
    period("re4_3", 2, 2, 1'b1, 4, 1'b0, 1'b0);
    period("re4_4", 2, 2, 1'b1, 4, 1'b1, 1'b0);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("dis.locked", 32'(o_locked), 32'd0);
    check("dis.valid", 32'(o_valid), 32'd0);
    check("dis.ratio_held", 32'(o_ratio), 32'd4);
    check("dis.state_idle", 32'(dbg_state), 32'd0);
    period("dis_1", 2, 2, 1'b0, 0, 1'b0, 1'b0);
    period("dis_2", 2, 2, 1'b0, 0, 1'b0, 1'b0);
    check("dis.ratio_held2", 32'(o_ratio), 32'd4);

    // re-enable: first edge only starts timing
    @(negedge clk);
    en = 1'b1;
    repeat (2) @(negedge clk);
    period("ren_1", 2, 2, 1'b0, 0, 1'b0, 1'b0);
    period("ren_2", 2, 2, 1'b1, 4, 1'b0, 1'b0);
    period("ren_3", 2, 2, 1'b1, 4, 1'b0, 1'b0);
    period("ren_4", 2, 2, 1'b1, 4, 1'b0, 1'b0);
    period("ren_5", 2, 2, 1'b1, 4, 1'b1, 1'b0);

    // asynchronous reset with a measurement result pending
    @(negedge clk);
    div_clk = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst.ratio", 32'(o_ratio), 32'd0);
    check("arst.valid", 32'(o_valid), 32'd0);
    check("arst.locked", 32'(o_locked), 32'd0);
    check("arst.overflow", 32'(o_overflow), 32'd0);
    check("arst.state", 32'(dbg_state), 32'd0);
    div_clk = 1'b0;
    @(negedge clk);
    check("arst.no_pending_valid", 32'(o_valid), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    period("post_1", 2, 2, 1'b0, 0, 1'b0, 1'b0);
    period("post_2", 2, 2, 1'b1, 4, 1'b0, 1'b0);
    period("post_3", 2, 2, 1'b1, 4, 1'b0, 1'b0);
    period("post_4", 2, 2, 1'b1, 4, 1'b0, 1'b0);
    period("post_5", 2, 2, 1'b1, 4, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
